// File: rtl/rom_map_pkg.sv
// ROM set memory map, FSM state and error encodings shared by the ROM download controller.
package rom_map_pkg;

    localparam int unsigned ROM_TOTAL    = 'h18500;
    localparam int unsigned REGION_COUNT = 17;
    localparam int unsigned EPROM_COUNT  = 12;
    localparam int unsigned EPROM_BASE   = 'h0;
    localparam int unsigned EPROM_SIZE   = 'h2000;
    localparam int unsigned PROM_BASE    = 'h18000;
    localparam int unsigned PROM_SIZE    = 'h100;

    typedef enum logic [2:0] {StIdle, StLoad, StSettle, StRun, StFail} load_state_e;

    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrShort    = 2'd1,
        ErrSeq      = 2'd2,
        ErrOverflow = 2'd3
    } err_code_e;

    // Regions 0..11 are the EPROMs, 12..16 the colour PROMs and LUTs packed after them.
    function automatic logic [24:0] region_base(input int unsigned idx);
        if (idx < EPROM_COUNT) return 25'(EPROM_BASE + idx * EPROM_SIZE);
        return 25'(PROM_BASE + (idx - EPROM_COUNT) * PROM_SIZE);
    endfunction

    function automatic logic [24:0] region_size(input int unsigned idx);
        if (idx < EPROM_COUNT) return 25'(EPROM_SIZE);
        return 25'(PROM_SIZE);
    endfunction

endpackage

// File: rtl/rom_region_dec.sv
// Combinational byte-address to one-hot ROM region decode; addresses past the map give all zero.
module rom_region_dec
    import rom_map_pkg::*;
(
    input  logic [24:0]             addr,
    output logic [REGION_COUNT-1:0] region_cs
);

    always_comb begin
        region_cs = '0;
        for (int unsigned i = 0; i < REGION_COUNT; i++) begin
            if (addr >= region_base(i) && addr < region_base(i) + region_size(i)) begin
                region_cs[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// Accepts an in-order HPS ROM download, forwards bytes to the ROM dpram and releases
// the game core only after a complete, gap-free set has been received.
module rom_load_ctrl
    import rom_map_pkg::*;
#(
    parameter int unsigned ROM_INDEX     = 0,
    parameter int unsigned ROM_SIZE      = ROM_TOTAL,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    ioctl_download,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic                    dl_wr,
    output logic [24:0]             dl_addr,
    output logic [7:0]              dl_data,
    output logic [REGION_COUNT-1:0] region_cs,
    output logic                    core_rst_n,
    output logic                    load_done,
    output logic                    load_error,
    output logic [1:0]              err_code
);

    localparam logic [24:0] RomSize  = 25'(ROM_SIZE);
    localparam logic [7:0]  RomIndex = 8'(ROM_INDEX);

    load_state_e             state_q;
    err_code_e               err_q, err_d;
    logic [24:0]             count_q, count_d;
    logic [31:0]             settle_cnt_q;
    logic                    dl_q;
    logic                    dl_rise, dl_fall;
    logic                    wr_over, wr_seq, wr_ok;
    logic [REGION_COUNT-1:0] dec_cs;

    rom_region_dec u_region_dec (
        .addr      (ioctl_addr),
        .region_cs (dec_cs)
    );

    assign err_code = err_q;

    // Strobe classification and the counter/error that result from it; only applied in LOAD.
    always_comb begin
        dl_rise = ioctl_download & ~dl_q;
        dl_fall = ~ioctl_download & dl_q;
        wr_over = ioctl_wr && (ioctl_addr >= RomSize);
        wr_seq  = ioctl_wr && !wr_over && (ioctl_addr != count_q);
        wr_ok   = ioctl_wr && !wr_over && !wr_seq;
        count_d = wr_ok ? count_q + 25'd1 : count_q;
        err_d   = err_q;
        if (err_q == ErrNone) begin
            if (wr_over) begin
                err_d = ErrOverflow;
            end else if (wr_seq) begin
                err_d = ErrSeq;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            err_q        <= ErrNone;
            count_q      <= '0;
            settle_cnt_q <= '0;
            dl_q         <= 1'b1;  // a download already active at release is not a new edge
            dl_wr        <= 1'b0;
            dl_addr      <= '0;
            dl_data      <= '0;
            region_cs    <= '0;
            core_rst_n   <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            dl_q      <= ioctl_download;
            dl_wr     <= 1'b0;
            region_cs <= '0;
            case (state_q)
                StIdle, StRun, StFail: begin
                    if (dl_rise && ioctl_index == RomIndex) begin
                        state_q    <= StLoad;
                        count_q    <= '0;
                        err_q      <= ErrNone;
                        core_rst_n <= 1'b0;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                StLoad: begin
                    if (wr_ok) begin
                        dl_wr     <= 1'b1;
                        dl_addr   <= ioctl_addr;
                        dl_data   <= ioctl_dout;
                        region_cs <= dec_cs;
                    end
                    count_q <= count_d;
                    err_q   <= err_d;
                    // Length check uses the post-strobe count so a final coincident byte counts.
                    if (dl_fall) begin
                        if (err_d != ErrNone) begin
                            state_q    <= StFail;
                            load_error <= 1'b1;
                        end else if (count_d == RomSize) begin
                            state_q      <= StSettle;
                            settle_cnt_q <= '0;
                        end else begin
                            state_q    <= StFail;
                            err_q      <= ErrShort;
                            load_error <= 1'b1;
                        end
                    end
                end
                StSettle: begin
                    if (settle_cnt_q + 32'd1 >= SETTLE_CYCLES) begin
                        state_q    <= StRun;
                        core_rst_n <= 1'b1;
                        load_done  <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Randomized bench for rom_load_ctrl against a behavioural download model; ROM size is
// scaled down to keep runtime short, and the full map is exercised on a standalone decoder.
module tb_rom_load_ctrl;

    localparam int RomSize = 'h2100;
    localparam int Settle  = 16;

    logic        clk;
    logic        rst_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic [16:0] region_cs;
    logic        core_rst_n;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;
    logic [24:0] dec_addr;
    logic [16:0] dec_cs;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    // Reference model state
    bit m_loading = 0;
    int m_count   = 0;
    int m_err     = 0;

    rom_load_ctrl #(
        .ROM_INDEX     (0),
        .ROM_SIZE      (RomSize),
        .SETTLE_CYCLES (Settle)
    ) dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .region_cs      (region_cs),
        .core_rst_n     (core_rst_n),
        .load_done      (load_done),
        .load_error     (load_error),
        .err_code       (err_code)
    );

    rom_region_dec u_dec (
        .addr      (dec_addr),
        .region_cs (dec_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] model_region(input int a);
        logic [16:0] r;
        r = '0;
        if (a < 'h18000) r[a / 'h2000] = 1'b1;
        else if (a < 'h18500) r[12 + (a - 'h18000) / 'h100] = 1'b1;
        return r;
    endfunction

    function automatic bit model_wr(input int a);
        if (!m_loading) return 1'b0;
        if (a >= RomSize) begin
            if (m_err == 0) m_err = 3;
            return 1'b0;
        end
        if (a != m_count) begin
            if (m_err == 0) m_err = 2;
            return 1'b0;
        end
        m_count++;
        return 1'b1;
    endfunction

    function automatic void model_fall();
        m_loading = 1'b0;
        if (m_err == 0 && m_count != RomSize) m_err = 1;
    endfunction

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(posedge clk); #1;
        if (idx == 8'd0) begin
            m_loading = 1'b1;
            m_count   = 0;
            m_err     = 0;
        end
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        @(posedge clk); #1;
        if (m_loading) model_fall();
    endtask

    // One strobe per clock from address 'first'; optionally drop download on the last strobe.
    task automatic stream(input int first, input int n, input bit drop_at_end, input string tag);
        for (int i = 0; i < n; i++) begin
            int          a;
            logic [7:0]  d;
            bit          acc;
            logic [16:0] cs_exp;
            a      = first + i;
            d      = 8'($urandom);
            acc    = model_wr(a);
            cs_exp = acc ? model_region(a) : 17'd0;
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(a);
            ioctl_dout = d;
            if (drop_at_end && i == n - 1) ioctl_download = 1'b0;
            @(posedge clk); #1;
            ioctl_wr = 1'b0;
            if (drop_at_end && i == n - 1) model_fall();
            if (dl_wr === 1'b1) pulses++;
            vectors++;
            if (dl_wr !== acc || region_cs !== cs_exp
                || (acc && (dl_addr !== 25'(a) || dl_data !== d))) begin
                miscompares++;
                $display("FAIL %s byte %0h: got wr=%b addr=%0h data=%0h cs=%0h, want wr=%b addr=%0h data=%0h cs=%0h",
                         tag, a, dl_wr, dl_addr, dl_data, region_cs, acc, a, d, cs_exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({dl_wr, dl_addr, dl_data, region_cs} !== '0) begin
            miscompares++;
            $display("FAIL reset_dl: got wr=%b addr=%0h data=%0h cs=%0h, want all 0",
                     dl_wr, dl_addr, dl_data, region_cs);
        end
        vectors++;
        if ({core_rst_n, load_done, load_error, err_code} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_status: got core_rst_n=%b done=%b error=%b err=%0d, want 0",
                     core_rst_n, load_done, load_error, err_code);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_load();
        pulses = 0;
        start_dl(8'd0);
        stream(0, RomSize, 1'b1, "full");
        vectors++;
        if (pulses != RomSize) begin
            miscompares++;
            $display("FAIL full_pulses: got %0d, want %0d", pulses, RomSize);
        end
        for (int k = 1; k <= Settle; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (core_rst_n !== (k == Settle) || load_done !== (k == Settle) || load_error !== 1'b0) begin
                miscompares++;
                $display("FAIL settle_cycle%0d: got core_rst_n=%b done=%b error=%b, want %b %b 0",
                         k, core_rst_n, load_done, load_error, k == Settle, k == Settle);
            end
        end
        vectors++;
        if (err_code !== 2'd0 || dl_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL full_end: got err=%0d wr=%b, want 0 0", err_code, dl_wr);
        end
    endtask

    task automatic test_other_index();
        start_dl(8'd1);
        stream(0, 20, 1'b0, "other_index");
        end_dl();
        vectors++;
        if (load_done !== 1'b1 || core_rst_n !== 1'b1 || load_error !== 1'b0) begin
            miscompares++;
            $display("FAIL other_index: got done=%b core_rst_n=%b error=%b, want 1 1 0",
                     load_done, core_rst_n, load_error);
        end
    endtask

    task automatic test_short();
        int n;
        n = $urandom_range(64, 512);
        start_dl(8'd0);
        vectors++;
        if (core_rst_n !== 1'b0 || load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reload_drop: got core_rst_n=%b done=%b, want 0 0", core_rst_n, load_done);
        end
        stream(0, n, 1'b0, "short");
        end_dl();
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (err_code !== 2'(m_err) || load_error !== 1'b1 || core_rst_n !== 1'b0 || load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL short_end: got err=%0d error=%b core_rst_n=%b done=%b, want %0d 1 0 0",
                     err_code, load_error, core_rst_n, load_done, m_err);
        end
    endtask

    task automatic test_skip();
        start_dl(8'd0);
        stream(0, 'h101, 1'b0, "skip_pre");
        stream('h102, 1, 1'b0, "skip_gap");
        stream('h103, 4, 1'b0, "skip_post");
        stream('h101, 1, 1'b1, "skip_resume");
        @(posedge clk); #1;
        vectors++;
        if (err_code !== 2'(m_err) || load_error !== 1'b1 || core_rst_n !== 1'b0) begin
            miscompares++;
            $display("FAIL skip_end: got err=%0d error=%b core_rst_n=%b, want %0d 1 0",
                     err_code, load_error, core_rst_n, m_err);
        end
    endtask

    task automatic test_overflow();
        start_dl(8'd0);
        stream(0, RomSize, 1'b0, "ovf_full");
        stream(RomSize, 1, 1'b0, "ovf_write");
        stream(5, 1, 1'b0, "ovf_later_seq");
        end_dl();
        vectors++;
        if (err_code !== 2'(m_err) || load_error !== 1'b1 || load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_end: got err=%0d error=%b done=%b, want %0d 1 0",
                     err_code, load_error, load_done, m_err);
        end
    endtask

    task automatic test_reset_mid();
        start_dl(8'd0);
        stream(0, 'h1000, 1'b0, "rst_pre");
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h1000;
        ioctl_dout = 8'($urandom);
        rst_n      = 1'b0;
        @(posedge clk); #1;
        ioctl_wr  = 1'b0;
        m_loading = 1'b0;
        m_count   = 0;
        m_err     = 0;
        vectors++;
        if ({dl_wr, dl_addr, dl_data, region_cs, core_rst_n, load_done, load_error, err_code} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got wr=%b addr=%0h data=%0h cs=%0h core_rst_n=%b done=%b error=%b err=%0d, want all 0",
                     dl_wr, dl_addr, dl_data, region_cs, core_rst_n, load_done, load_error, err_code);
        end
        rst_n = 1'b1;
        stream('h1001, 3, 1'b0, "rst_stale_dl");
        end_dl();
        vectors++;
        if (load_error !== 1'b0 || err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_stale_end: got error=%b err=%0d, want 0 0", load_error, err_code);
        end
        start_dl(8'd0);
        stream(0, RomSize, 1'b1, "rst_reload");
        repeat (Settle) @(posedge clk);
        #1;
        vectors++;
        if (load_done !== 1'b1 || core_rst_n !== 1'b1 || err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_reload: got done=%b core_rst_n=%b err=%0d, want 1 1 0",
                     load_done, core_rst_n, err_code);
        end
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 6; it++) begin
            int n;
            int kind;
            n    = $urandom_range(16, 128);
            kind = $urandom_range(0, 2);
            start_dl(8'd0);
            stream(0, n, 1'b0, "rnd_body");
            if (kind == 1) stream(n + $urandom_range(1, 50), 1, 1'b0, "rnd_gap");
            if (kind == 2) stream(RomSize + $urandom_range(0, 1000), 1, 1'b0, "rnd_ovf");
            stream(m_count, 2, 1'b1, "rnd_tail");
            @(posedge clk); #1;
            vectors++;
            if (err_code !== 2'(m_err) || load_error !== (m_err != 0) || load_done !== 1'b0) begin
                miscompares++;
                $display("FAIL random_load%0d: got err=%0d error=%b done=%b, want %0d %b 0",
                         it, err_code, load_error, load_done, m_err, m_err != 0);
            end
        end
    endtask

    task automatic test_decoder();
        int bnd[10] = '{0, 'h1FFF, 'h2000, 'h17FFF, 'h18000, 'h180FF, 'h18100, 'h184FF, 'h18500, 'h1FFFFFF};
        for (int i = 0; i < 210; i++) begin
            int a;
            if (i < 10) a = bnd[i];
            else if (i < 200) a = $urandom_range(0, 'h18600);
            else a = int'($urandom & 32'h1FF_FFFF);
            dec_addr = 25'(a);
            #1;
            vectors++;
            if (dec_cs !== model_region(a)) begin
                miscompares++;
                $display("FAIL decode addr %0h: got %0h, want %0h", a, dec_cs, model_region(a));
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        dec_addr       = '0;
        test_reset();
        test_full_load();
        test_other_index();
        test_short();
        test_skip();
        test_overflow();
        test_reset_mid();
        test_random_loads();
        test_decoder();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
